pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multi-cycle control FSM for the RV32I program counter register.
- Sequences fetch → execute → PC update. Handshakes with instruction memory and waits for datapath branch/jump resolution.
- Drives the PC register's en / jalr / number_instr inputs:
  - jalr == 2'b00: PC adds number_instr to the current value.
  - jalr != 2'b00: PC loads number_instr as an absolute value.
- Counts retired instructions.

Parameters:
- START_DELAY, 2, idle cycles after reset release before the first fetch (0–15).
- TRAP_VECTOR, 32'h0000_0100, absolute PC loaded on a misaligned target (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- imem_ready  in  1  instruction memory has accepted the request and instruction data is valid.
- resolve_valid  in  1  datapath has resolved the control flow of the current instruction (1-cycle pulse).
- is_jal  in  1  current instruction is JAL; qualified by resolve_valid.
- is_jalr  in  1  current instruction is JALR; qualified by resolve_valid.
- branch_taken  in  1  conditional branch taken; qualified by resolve_valid.
- imm  in  32  sign-extended immediate of the current instruction.
- rs1_val  in  32  rs1 operand, used for JALR.
- pc  in  32  current PC register value.
- stall  in  1  hold in EXEC; ignore resolve_valid.
- imem_req  out  1  fetch request.
- instr_valid  out  1  1-cycle pulse: fetched instruction is latched downstream.
- pc_en  out  1  PC register enable.
- pc_jalr  out  2  PC mode select.
- pc_number_instr  out  32  offset or absolute target.
- instret  out  32  retired-instruction counter.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state ← IDLE, delay counter ← 0.
  - All outputs 0: imem_req, instr_valid, pc_en, pc_jalr, pc_number_instr, instret, busy.
  - Reset mid-operation aborts any fetch or update. No pc_en pulse may follow the reset edge.
- All outputs are registered.
- IDLE:
  - Count START_DELAY cycles, then go to FETCH.
  - START_DELAY == 0: go to FETCH on the first cycle after reset release.
- FETCH:
  - imem_req = 1.
  - On imem_ready: next cycle instr_valid = 1 for exactly 1 cycle, imem_req = 0, go to EXEC.
  - imem_req stays high until imem_ready, with no timeout.
- EXEC:
  - Wait for resolve_valid with stall == 0.
  - stall == 1 wins over a simultaneous resolve_valid; that pulse is dropped, and the datapath must re-assert it after the stall.
  - On an accepted resolve, register the update below and go to UPDATE.
- Target select, in priority order:
  - is_jalr: pc_jalr = 2'b01, pc_number_instr = (rs1_val + imm) & ~32'h1, modulo-2^32 add.
  - else is_jal or branch_taken: pc_jalr = 2'b00, pc_number_instr = imm.
  - else: pc_jalr = 2'b00, pc_number_instr = 32'd4.
  - is_jal and is_jalr both high: is_jalr wins.
- UPDATE:
  - pc_en = 1 for exactly one cycle.
  - instret increments by 1, wrapping 32'hFFFF_FFFF → 0.
  - Next state FETCH.
  - pc_en falls to 0 in the FETCH cycle that follows. pc_jalr and pc_number_instr hold until the next update.
- Latency:
  - Fetch-accept to instr_valid: 1 cycle.
  - Accepted resolve to pc_en: 1 cycle.
  - Minimum loop with imem_ready tied high and resolve in the first EXEC cycle: 3 cycles per instruction (FETCH, EXEC, UPDATE).
- pc_en is never high outside UPDATE.

Optional Feature:
- Macro: PC_SEQ_MISALIGN_TRAP_EN.
- When defined, at resolve the computed effective target is checked:
  - effective target = pc + offset for JAL / taken branch; the masked value for JALR.
  - If target[1:0] != 2'b00: pc_jalr = 2'b10, pc_number_instr = TRAP_VECTOR.
  - Output misalign_trap (1 bit, reset 0) pulses in the UPDATE cycle.
  - instret does not increment on a trapped update.
- When undefined:
  - No check is made, the misalign_trap port is absent, and misaligned targets are loaded as computed.

Test Plan:
- Reset, START_DELAY = 2, imem_ready held 1 → imem_req rises in cycle 3 after reset release; instr_valid pulses 1 cycle later.
- Sequential instruction: resolve_valid with no jump → pc_en = 1, pc_jalr = 0, pc_number_instr = 4; instret 0 → 1.
- JALR with rs1_val = 32'h1003, imm = 32'h4 → pc_jalr = 2'b01, pc_number_instr = 32'h1006.
- Taken branch imm = 32'hFFFF_FFF8 with stall asserted in the same cycle → no update; after stall drops and resolve is re-pulsed → pc_number_instr = 32'hFFFF_FFF8.
- rst dropped while in EXEC, and separately while in UPDATE → next cycle all outputs 0, state IDLE, no further pc_en.
- With PC_SEQ_MISALIGN_TRAP_EN: pc = 32'h100, JAL imm = 32'h6 → pc_jalr = 2'b10, pc_number_instr = 32'h100, misalign_trap pulses, instret unchanged.

Source files
------------

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch / execute / PC-update sequencer for the RV32I program counter.
// Optional misaligned-target trap enabled by defining PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter int unsigned START_DELAY = 2,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        resolve_valid,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_val,
  input  logic [31:0] pc,
  input  logic        stall,
  output logic        imem_req,
  output logic        instr_valid,
  output logic        pc_en,
  output logic [1:0]  pc_jalr,
  output logic [31:0] pc_number_instr,
  output logic [31:0] instret,
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  output logic        misalign_trap,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StUpdate} state_e;

  state_e      state_q, state_d;
  logic [3:0]  delay_q, delay_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic        pc_en_q, pc_en_d;
  logic [1:0]  pc_jalr_q, pc_jalr_d;
  logic [31:0] pc_num_q, pc_num_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;
  logic        busy_q, busy_d;

  logic        accept;
  logic [31:0] jalr_tgt;
  logic [1:0]  sel_jalr;
  logic [31:0] sel_num;
  logic        sel_misalign;

  // stall always wins; a resolve pulse seen during stall is dropped
  assign accept = (state_q == StExec) && resolve_valid && !stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      delay_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_en_q       <= 1'b0;
      pc_jalr_q     <= 2'b00;
      pc_num_q      <= '0;
      instret_q     <= '0;
      trap_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      delay_q       <= delay_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      pc_en_q       <= pc_en_d;
      pc_jalr_q     <= pc_jalr_d;
      pc_num_q      <= pc_num_d;
      instret_q     <= instret_d;
      trap_q        <= trap_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    unique case (state_q)
      StIdle: begin
        if (delay_q == START_DELAY[3:0]) state_d = StFetch;
        else                             delay_d = delay_q + 4'd1;
      end
      StFetch:  if (imem_ready) state_d = StExec;
      StExec:   if (accept) state_d = StUpdate;
      StUpdate: state_d = StFetch;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    jalr_tgt     = (rs1_val + imm) & ~32'h1;
    sel_misalign = 1'b0;
    if (is_jalr) begin
      sel_jalr = 2'b01;
      sel_num  = jalr_tgt;
    end else if (is_jal || branch_taken) begin
      sel_jalr = 2'b00;
      sel_num  = imm;
    end else begin
      sel_jalr = 2'b00;
      sel_num  = 32'd4;
    end
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    if ((is_jalr || is_jal || branch_taken) &&
        ((is_jalr ? jalr_tgt[1:0] : (pc[1:0] + imm[1:0])) != 2'b00)) begin
      sel_jalr     = 2'b10;
      sel_num      = TRAP_VECTOR;
      sel_misalign = 1'b1;
    end
`endif
  end

`ifndef PC_SEQ_MISALIGN_TRAP_EN
  logic unused_pc;
  assign unused_pc = ^{pc, TRAP_VECTOR};
`endif

  always_comb begin
    imem_req_d    = (state_d == StFetch);
    instr_valid_d = (state_q == StFetch) && imem_ready;
    pc_en_d       = accept;
    busy_d        = (state_d != StIdle);
    pc_jalr_d     = accept ? sel_jalr : pc_jalr_q;
    pc_num_d      = accept ? sel_num : pc_num_q;
    instret_d     = (accept && !sel_misalign) ? instret_q + 32'd1 : instret_q;
    trap_d        = accept && sel_misalign;
  end

  assign imem_req        = imem_req_q;
  assign instr_valid     = instr_valid_q;
  assign pc_en           = pc_en_q;
  assign pc_jalr         = pc_jalr_q;
  assign pc_number_instr = pc_num_q;
  assign instret         = instret_q;
  assign busy            = busy_q;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign misalign_trap   = trap_q;
`else
  logic unused_trap;
  assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (default START_DELAY = 2).
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_ready = 1'b0, resolve_valid = 1'b0, stall = 1'b0;
  logic        is_jal = 1'b0, is_jalr = 1'b0, branch_taken = 1'b0;
  logic [31:0] imm = '0, rs1_val = '0, pc = '0;
  logic        imem_req, instr_valid, pc_en, busy;
  logic [1:0]  pc_jalr;
  logic [31:0] pc_number_instr, instret;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  pc_sequencer dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .resolve_valid(resolve_valid),
    .is_jal(is_jal), .is_jalr(is_jalr), .branch_taken(branch_taken), .imm(imm),
    .rs1_val(rs1_val), .pc(pc), .stall(stall), .imem_req(imem_req),
    .instr_valid(instr_valid), .pc_en(pc_en), .pc_jalr(pc_jalr),
    .pc_number_instr(pc_number_instr), .instret(instret),
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    .misalign_trap(misalign_trap),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jal, jalr, br;
    logic [31:0] imm, rs1, pcv;
    logic [1:0]  e_jalr;
    logic [31:0] e_num;
    logic        e_trap;
  } vec_t;

  vec_t        vecs[6];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] exp_instret = 0;
  logic [31:0] last_num;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (instr_valid) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic set_ctl(input logic rv, input logic j, input logic jr, input logic b,
                         input logic [31:0] im, input logic [31:0] r, input logic [31:0] p);
    resolve_valid = rv; is_jal = j; is_jalr = jr; branch_taken = b;
    imm = im; rs1_val = r; pc = p;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".imem_req"}, 32'(imem_req), 0);
    chk({name, ".instr_valid"}, 32'(instr_valid), 0);
    chk({name, ".pc_en"}, 32'(pc_en), 0);
    chk({name, ".pc_jalr"}, 32'(pc_jalr), 0);
    chk({name, ".pc_num"}, pc_number_instr, 0);
    chk({name, ".instret"}, instret, 0);
    chk({name, ".busy"}, 32'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 2'b00, 32'd4, 1'b0};
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h4, 32'h1003, 32'h0, 2'b10, 32'h100, 1'b1};
`else
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h4, 32'h1003, 32'h0, 2'b01, 32'h1006, 1'b0};
`endif
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 2'b00, 32'h20, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h100, 2'b00, 32'hFFFF_FFF8, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h2000, 32'h0, 2'b01, 32'h2010, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h2, 32'hFFFF_FFFF, 32'h0, 2'b01, 32'h0, 1'b0};

    // reset state
    repeat (3) step();
    chk_all_zero("reset");

    // start-up delay: imem_req rises on the third edge after release
    imem_ready = 1'b1;
    rst = 1'b1;
    step(); chk("dly1.imem_req", 32'(imem_req), 0); chk("dly1.busy", 32'(busy), 0);
    step(); chk("dly2.imem_req", 32'(imem_req), 0);
    step(); chk("fetch.imem_req", 32'(imem_req), 1); chk("fetch.busy", 32'(busy), 1);
    chk("fetch.instr_valid", 32'(instr_valid), 0);
    step(); chk("exec.instr_valid", 32'(instr_valid), 1); chk("exec.imem_req", 32'(imem_req), 0);
    chk("exec.pc_en", 32'(pc_en), 0);

    // table: one full 3-cycle loop per vector
    foreach (vecs[i]) begin
      set_ctl(1'b1, vecs[i].jal, vecs[i].jalr, vecs[i].br, vecs[i].imm, vecs[i].rs1,
              vecs[i].pcv);
      step();
      if (!vecs[i].e_trap) exp_instret = exp_instret + 1;
      chk($sformatf("v%0d.pc_en", i), 32'(pc_en), 1);
      chk($sformatf("v%0d.pc_jalr", i), 32'(pc_jalr), 32'(vecs[i].e_jalr));
      chk($sformatf("v%0d.pc_num", i), pc_number_instr, vecs[i].e_num);
      chk($sformatf("v%0d.instret", i), instret, exp_instret);
      chk($sformatf("v%0d.instr_valid", i), 32'(instr_valid), 0);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      chk($sformatf("v%0d.trap", i), 32'(misalign_trap), 32'(vecs[i].e_trap));
`endif
      set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      step();
      chk($sformatf("v%0d.pc_en_fall", i), 32'(pc_en), 0);
      chk($sformatf("v%0d.refetch", i), 32'(imem_req), 1);
      chk($sformatf("v%0d.hold_num", i), pc_number_instr, vecs[i].e_num);
      step();
      chk($sformatf("v%0d.next_valid", i), 32'(instr_valid), 1);
    end
    last_num = 32'h0;

    // stall beats a simultaneous resolve; re-pulse after stall completes the update
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h100);
    stall = 1'b1;
    step(); chk("stall.pc_en", 32'(pc_en), 0); chk("stall.num", pc_number_instr, last_num);
    resolve_valid = 1'b0;
    step(); chk("stall2.pc_en", 32'(pc_en), 0);
    stall = 1'b0;
    step(); chk("unstall.pc_en", 32'(pc_en), 0);
    resolve_valid = 1'b1;
    step();
    exp_instret = exp_instret + 1;
    chk("repulse.pc_en", 32'(pc_en), 1);
    chk("repulse.num", pc_number_instr, 32'hFFFF_FFF8);
    chk("repulse.instret", instret, exp_instret);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    wait_valid("after_stall.valid");

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 32'h6, 32'h0, 32'h100);
    step();
    chk("trap.pc_en", 32'(pc_en), 1);
    chk("trap.pc_jalr", 32'(pc_jalr), 2);
    chk("trap.num", pc_number_instr, 32'h100);
    chk("trap.pulse", 32'(misalign_trap), 1);
    chk("trap.instret", instret, exp_instret);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(); chk("trap.fall", 32'(misalign_trap), 0);
    wait_valid("after_trap.valid");
`endif

    // reset while in EXEC, with a resolve pending
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    step();
    chk_all_zero("rst_exec");
    resolve_valid = 1'b0;
    imem_ready = 1'b0;
    rst = 1'b1;
    step(); chk("rst_exec.idle_pc_en", 32'(pc_en), 0); chk("rst_exec.idle_busy", 32'(busy), 0);
    step(); step();
    // no timeout: imem_req held until ready
    repeat (5) step();
    chk("norecv.imem_req", 32'(imem_req), 1);
    chk("norecv.instr_valid", 32'(instr_valid), 0);
    imem_ready = 1'b1;
    step(); chk("late.instr_valid", 32'(instr_valid), 1);
    resolve_valid = 1'b1;
    step();
    chk("pre_rst.pc_en", 32'(pc_en), 1); chk("pre_rst.instret", instret, 1);
    resolve_valid = 1'b0;

    // reset while in UPDATE
    rst = 1'b0;
    step();
    chk_all_zero("rst_upd");
    rst = 1'b1;
    step(); chk("rst_upd.pc_en1", 32'(pc_en), 0);
    step(); chk("rst_upd.pc_en2", 32'(pc_en), 0); chk("rst_upd.instret", instret, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
